// File: rtl/mem_copy_ctrl.sv
// mem_copy_ctrl: byte copy engine in front of the banked memory.
// Reads one source byte, then writes it, stopping on a ROM target.
module mem_copy_ctrl #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int ROM_LIMIT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] count,
  output logic [DATA_W-1:0] csum
);

  localparam logic [ADDR_W:0] RomLim = ROM_LIMIT[ADDR_W:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] src_q, dst_q, len_q, idx_q;
  logic [DATA_W-1:0] data_q, csum_q;
  logic [ADDR_W-1:0] count_q;
  logic              err_q;

  logic [ADDR_W-1:0] rd_addr, wr_addr, idx_nxt;
  logic              wr_rom, last;

  assign rd_addr = src_q + idx_q;
  assign wr_addr = dst_q + idx_q;
  assign idx_nxt = idx_q + 1'b1;
  assign wr_rom  = {1'b0, wr_addr} < RomLim;
  assign last    = idx_nxt == len_q;

  assign err   = err_q;
  assign count = count_q;
  assign csum  = csum_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_d   = state_q;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        busy     = 1'b1;
        mem_addr = rd_addr;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        busy     = 1'b1;
        mem_addr = wr_addr;
        if (wr_rom) begin
          state_d = S_DONE;
        end else begin
          mem_we    = 1'b1;
          mem_wdata = data_q;
          state_d   = last ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: latch request, capture read byte, account writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      csum_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            src_q   <= src_addr;
            dst_q   <= dst_addr;
            len_q   <= len;
            idx_q   <= '0;
            count_q <= '0;
            csum_q  <= '0;
            err_q   <= 1'b0;
          end
        end
        S_READ: begin
          data_q <= mem_rdata;
        end
        S_WRITE: begin
          if (wr_rom) begin
            err_q <= 1'b1;
          end else begin
            count_q <= count_q + 1'b1;
            csum_q  <= csum_q + data_q;
            idx_q   <= idx_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
